// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width; never below one bit so the counter always exists.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_half_add_1bit.sv
// Single-bit full adder; the only arithmetic in the serial adder datapath.
module full_half_add_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    logic half_sum;

    assign half_sum = i_a ^ i_b;
    assign o_sum    = half_sum ^ i_cin;
    assign o_carry  = (i_a & i_b) | (i_cin & half_sum);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that streams operands LSB-first through one full adder.
// Optional SERIAL_ADD_OVF_EN adds o_ovf (signed overflow of the final result).
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_half_add_1bit u_fa (
        .i_a    (a_sh[0]),
        .i_b    (b_sh[0]),
        .i_cin  (carry_q),
        .o_sum  (fa_sum),
        .o_carry(fa_carry)
    );

    // Result fills from the MSB down; on the last bit this is the full sum.
    assign res_next = {fa_sum, res_sh};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state   <= ST_RUN;
                        a_sh    <= i_a;
                        b_sh    <= i_b;
                        carry_q <= i_cin;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next[WIDTH-1:1];
                    carry_q <= fa_carry;
                    if (cnt == CNT_LAST) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_sum  <= res_next;
                        o_cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q here is the carry into the MSB position
                        o_ovf  <= carry_q ^ fa_carry;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and model-checked bench for bit_serial_adder at WIDTH=8 and WIDTH=13.
module tb_bit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;

    logic        start13;
    logic [12:0] a13;
    logic [12:0] b13;
    logic        cin13;
    logic        busy13;
    logic        done13;
    logic [12:0] sum13;
    logic        cout13;
    logic        ovf13;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .i_cin  (cin),
        .o_busy (busy),
        .o_done (done),
        .o_sum  (sum),
        .o_cout (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .o_ovf  (ovf)
`endif
    );

    bit_serial_adder #(.WIDTH(13)) dut13 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start13),
        .i_a    (a13),
        .i_b    (b13),
        .i_cin  (cin13),
        .o_busy (busy13),
        .o_done (done13),
        .o_sum  (sum13),
        .o_cout (cout13)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .o_ovf  (ovf13)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf   = 1'b0;
    assign ovf13 = 1'b0;
`endif

    // Issue one start pulse and wait (bounded) for the done cycle; returns in the done cycle.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int busy_n, output bit got);
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busy_n = 0; got = 1'b0; s = '0; co = 1'b0; ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1; s = sum; co = cout; ov = ovf;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic add13(input logic [12:0] ta, input logic [12:0] tb2, input logic tc,
                         output logic [12:0] s, output logic co, output logic ov,
                         output int busy_n, output bit got);
        a13 = ta; b13 = tb2; cin13 = tc; start13 = 1'b1;
        @(posedge clk); #1;
        start13 = 1'b0; busy_n = 0; got = 1'b0; s = '0; co = 1'b0; ov = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done13) begin
                got = 1'b1; s = sum13; co = cout13; ov = ovf13;
                break;
            end
            if (busy13) busy_n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b done=%b, need busy=0 done=0", busy, done);
        end
        n_vec++;
        if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: sum=%h cout=%b ovf=%b, need 00/0/0", sum, cout, ovf);
        end
        n_vec++;
        if (busy13 !== 1'b0 || done13 !== 1'b0 || sum13 !== 13'h0 || cout13 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w13: busy=%b done=%b sum=%h cout=%b, need all 0",
                     busy13, done13, sum13, cout13);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; logic ov; int bn; bit got;
        add8(8'hFF, 8'h01, 1'b0, s, co, ov, bn, got);
        n_vec++;
        if (!got || bn != 8) begin
            n_err++;
            $display("FAIL basic_latency: done=%b busy_cycles=%0d, need done=1 busy_cycles=8", got, bn);
        end
        n_vec++;
        if (s !== 8'h00 || co !== 1'b1) begin
            n_err++;
            $display("FAIL basic_result: sum=%h cout=%b, need 00/1", s, co);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pulse_hold: done=%b busy=%b sum=%h cout=%b, need 0/0/00/1",
                     done, busy, sum, cout);
        end
    endtask

    task automatic test_hold_start();
        int bn; bit got; logic [7:0] s; logic co;
        a = 8'h3C; b = 8'hA5; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        bn = 0; got = 1'b0; s = '0; co = 1'b0;
        n_vec++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL hold_prev_result: sum=%h cout=%b, need 00/1", sum, cout);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) begin got = 1'b1; s = sum; co = cout; break; end
            if (busy) bn++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (!got || bn != 8 || s !== 8'hE2 || co !== 1'b0) begin
            n_err++;
            $display("FAIL hold_start_run: done=%b busy_cycles=%0d sum=%h cout=%b, need 1/8/e2/0",
                     got, bn, s, co);
        end
        // start still high in DONE: a new add begins at once
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'hE2 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL hold_restart: busy=%b done=%b sum=%h cout=%b, need 1/0/e2/0",
                     busy, done, sum, cout);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!got || sum !== 8'hE2 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL hold_second: done=%b sum=%h cout=%b, need 1/e2/0", got, sum, cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic co; logic ov; int bn; bit got;
        add8(8'h80, 8'h80, 1'b0, s, co, ov, bn, got);
        n_vec++;
        if (!got || bn != 8 || s !== 8'h00 || co !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_result: done=%b busy_cycles=%0d sum=%h cout=%b, need 1/8/00/1",
                     got, bn, s, co);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ovf: ovf=%b, need 1", ov);
        end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] s; logic co; logic ov; int bn; bit got; bit seen;
        add8(8'h12, 8'h34, 1'b0, s, co, ov, bn, got);
        n_vec++;
        if (!got || s !== 8'h46 || co !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pre: done=%b sum=%h cout=%b, need 1/46/0", got, s, co);
        end
        a = 8'hF0; b = 8'hF0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL abort_zero: busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
                     busy, done, sum, cout, ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_quiet: activity after abort=%b, need 0", seen);
        end
        add8(8'h55, 8'h2A, 1'b1, s, co, ov, bn, got);
        n_vec++;
        if (!got || bn != 8 || s !== 8'h80 || co !== 1'b0) begin
            n_err++;
            $display("FAIL abort_after: done=%b busy_cycles=%0d sum=%h cout=%b, need 1/8/80/0",
                     got, bn, s, co);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL abort_after_ovf: ovf=%b, need 1", ov);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ta, tb2, s; logic tc, co, ov, exp_ov; logic [8:0] exp;
        logic [12:0] ua, ub, s13; logic uc; logic [13:0] exp13; int bn; bit got;
        for (int n = 0; n < 200; n++) begin
            ta = 8'($urandom); tb2 = 8'($urandom); tc = 1'($urandom);
            exp = 9'(ta) + 9'(tb2) + 9'(tc);
            exp_ov = (ta[7] == tb2[7]) && (exp[7] != ta[7]);
            add8(ta, tb2, tc, s, co, ov, bn, got);
            n_vec++;
            if (!got || bn != 8 || {co, s} !== exp) begin
                n_err++;
                $display("FAIL rand8 %h+%h+%b: done=%b busy=%0d got=%h, need %h",
                         ta, tb2, tc, got, bn, {co, s}, exp);
            end
`ifdef SERIAL_ADD_OVF_EN
            n_vec++;
            if (ov !== exp_ov) begin
                n_err++;
                $display("FAIL rand8_ovf %h+%h+%b: ovf=%b, need %b", ta, tb2, tc, ov, exp_ov);
            end
`endif
        end
        for (int n = 0; n < 200; n++) begin
            ua = 13'($urandom); ub = 13'($urandom); uc = 1'($urandom);
            exp13 = 14'(ua) + 14'(ub) + 14'(uc);
            exp_ov = (ua[12] == ub[12]) && (exp13[12] != ua[12]);
            add13(ua, ub, uc, s13, co, ov, bn, got);
            n_vec++;
            if (!got || bn != 13 || {co, s13} !== exp13) begin
                n_err++;
                $display("FAIL rand13 %h+%h+%b: done=%b busy=%0d got=%h, need %h",
                         ua, ub, uc, got, bn, {co, s13}, exp13);
            end
`ifdef SERIAL_ADD_OVF_EN
            n_vec++;
            if (ov !== exp_ov) begin
                n_err++;
                $display("FAIL rand13_ovf %h+%h+%b: ovf=%b, need %b", ua, ub, uc, ov, exp_ov);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
